// File: rtl/load_store_unit.sv
// Memory-access stage: one load/store at a time on a req/ack bus with wait states.
// Formats store byte lanes, extends load data, and reports misaligned/illegal/timeout faults.
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        busy,
  output logic        done,
  output logic [31:0] load_data,
  output logic        fault,
  output logic [1:0]  fault_cause,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_e;

  localparam logic [1:0] C_NONE = 2'b00, C_MISAL = 2'b01, C_ILL = 2'b10, C_TMO = 2'b11;
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, ld_q, ld_d;
  logic [3:0]  strb_q, strb_d;
  logic        we_q, we_d;
  logic [1:0]  off_q, off_d, cause_q, cause_d;
  logic [2:0]  f3_q, f3_d;

  // request decode
  logic        load_ok, store_ok, illegal, misal;
  logic [3:0]  strb_fmt;
  logic [31:0] wdata_fmt;

  always_comb begin
    load_ok  = funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    store_ok = !funct3[2] && (funct3[1:0] != 2'b11);
    illegal  = (mem_read && mem_write) || (mem_read && !load_ok) || (mem_write && !store_ok);
    misal    = ((funct3[1:0] == 2'b01) && addr[0]) ||
               ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
    case (funct3[1:0])
      2'b00: begin
        strb_fmt  = 4'b0001 << addr[1:0];
        wdata_fmt = {4{store_data[7:0]}};
      end
      2'b01: begin
        strb_fmt  = addr[1] ? 4'b1100 : 4'b0011;
        wdata_fmt = {2{store_data[15:0]}};
      end
      default: begin
        strb_fmt  = 4'b1111;
        wdata_fmt = store_data;
      end
    endcase
  end

  // load lane extraction from the registered offset/width
  logic [31:0] rd_shift, ld_ext;
  logic [15:0] rd_half;

  always_comb begin
    rd_shift = bus_rdata >> {off_q, 3'b000};
    rd_half  = off_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (f3_q)
      3'b000:  ld_ext = {{24{rd_shift[7]}}, rd_shift[7:0]};
      3'b001:  ld_ext = {{16{rd_half[15]}}, rd_half};
      3'b100:  ld_ext = {24'd0, rd_shift[7:0]};
      3'b101:  ld_ext = {16'd0, rd_half};
      default: ld_ext = bus_rdata;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    strb_d  = strb_q;
    we_d    = we_q;
    off_d   = off_q;
    f3_d    = f3_q;
    cause_d = cause_q;
    ld_d    = ld_q;
    case (state_q)
      IDLE: begin
        if (start && (mem_read || mem_write)) begin
          if (illegal) begin
            state_d = DONE;
            cause_d = C_ILL;
          end else if (misal) begin
            state_d = DONE;
            cause_d = C_MISAL;
          end else begin
            state_d = REQ;
            cause_d = C_NONE;
            cnt_d   = 8'd0;
            addr_d  = {addr[31:2], 2'b00};
            we_d    = mem_write;
            strb_d  = mem_write ? strb_fmt : 4'b0000;
            wdata_d = wdata_fmt;
            off_d   = addr[1:0];
            f3_d    = funct3;
          end
        end
      end
      REQ: begin
        if (bus_ack) begin
          state_d = DONE;
          cnt_d   = 8'd0;
          if (!we_q) ld_d = ld_ext;
        end else if (cnt_q == CNT_LAST) begin
          state_d = DONE;
          cnt_d   = 8'd0;
          cause_d = C_TMO;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      strb_q  <= '0;
      we_q    <= 1'b0;
      off_q   <= '0;
      f3_q    <= '0;
      cause_q <= '0;
      ld_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      strb_q  <= strb_d;
      we_q    <= we_d;
      off_q   <= off_d;
      f3_q    <= f3_d;
      cause_q <= cause_d;
      ld_q    <= ld_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign fault       = done && (cause_q != C_NONE);
  assign fault_cause = done ? cause_q : 2'b00;
  assign bus_req     = (state_q == REQ);
  assign bus_we      = we_q;
  assign bus_addr    = addr_q;
  assign bus_wstrb   = strb_q;
  assign bus_wdata   = wdata_q;
  assign load_data   = ld_q;

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Memory-access stage directly downstream of the ALU in the RISC-V datapath. It takes the ALU result as the effective address, plus rs2 as store data, and runs one load or store at a time on a simple req/ack data bus with wait states. It generates byte enables and lane-replicated store data, then sign- or zero-extends load data for writeback. It also flags misaligned, illegal and timed-out accesses.

Parameters:
TIMEOUT_CYCLES, 64, number of REQ cycles without bus_ack before the access is aborted with a timeout fault (range 1..255).

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous reset, active-high
start  input  1  one-cycle access request from control; sampled only in IDLE
mem_read  input  1  access is a load
mem_write  input  1  access is a store
funct3  input  3  width/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU (loads only)
addr  input  32  effective address (ALU result)
store_data  input  32  rs2 value
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle pulse: access finished, success or fault
load_data  output  32  extended load result; held until next successful load
fault  output  1  valid with done; access failed
fault_cause  output  2  valid with fault: 01 misaligned, 10 illegal, 11 timeout
bus_req  output  1  bus request, held until ack or timeout
bus_we  output  1  1 = write
bus_addr  output  32  word address {addr[31:2],2'b00}
bus_wstrb  output  4  byte enables (0000 for loads)
bus_wdata  output  32  lane-replicated store data
bus_rdata  input  32  read data, valid with bus_ack
bus_ack  input  1  slave completion; sampled only while bus_req=1

Behaviour:
- Reset (async, active-high): state IDLE; all outputs 0, including load_data; timeout counter 0. Reset mid-access drops bus_req at once and abandons the access, with no done.
- FSM states: IDLE, REQ, DONE.
- IDLE + start:
  - mem_read=mem_write=0: ignored.
  - Both set, or illegal funct3 (loads 011/110/111; stores anything except 000/001/010): go to DONE, fault_cause=10.
  - Misaligned (H/HU/SH with addr[0]=1; W/SW with addr[1:0]!=00): go to DONE, fault_cause=01, no bus activity.
  - Otherwise: register bus_addr/we/wstrb/wdata, offset addr[1:0], funct3, then go to REQ.
- start outside IDLE is ignored. No queueing.
- REQ: bus_req=1 and all bus outputs stay stable.
  - On an edge with bus_ack=1: capture rdata (loads), go to DONE.
  - Counter increments each REQ cycle. After TIMEOUT_CYCLES REQ cycles with no ack, go to DONE with fault_cause=11.
- DONE: done=1 for exactly one cycle, then IDLE. Successful load updates load_data on entry to DONE. Faults and stores leave load_data unchanged.
- fault and fault_cause are meaningful only while done=1; they are 0 otherwise.
- Latency: start at T → bus_req from T+1. Ack seen at edge ending REQ cycle k (k≥1) → done at T+1+k. Fault paths: done at T+1.
- Store formatting:
  - SB: wstrb=0001<<addr[1:0], wdata={4{store_data[7:0]}}.
  - SH: wstrb=0011<<(2*addr[1]), wdata={2{store_data[15:0]}}.
  - SW: wstrb=1111, wdata=store_data.
- Load extraction: byte lane addr[1:0], half lane addr[1]. B/H sign-extend; BU/HU zero-extend; W passes through.
- bus_ack while bus_req=0 is ignored.

Test Plan:
- SW addr=0x100 store_data=0xDEADBEEF, ack in first REQ cycle → bus_addr=0x100, wstrb=1111, wdata=0xDEADBEEF, bus_we=1; done at T+2, fault=0.
- LB addr=0x103, rdata=0x80FF1234, ack after 3 wait cycles → load_data=0xFFFFFF80, done at T+5. Same access as LBU → load_data=0x00000080.
- LH addr=0x102, rdata=0x80FF1234 → load_data=0xFFFF80FF.
- SH addr=0x102 store_data=0x0000ABCD → wstrb=1100, wdata=0xABCDABCD.
- LW addr=0x101 → no bus_req; done+fault at T+1, cause=01. Load funct3=011 → cause=10. mem_read=mem_write=1 → cause=10. load_data unchanged after each.
- TIMEOUT_CYCLES=4, ack never → bus_req high exactly 4 cycles, then done with cause=11. A late ack after that is ignored.
- Reset in second REQ cycle → bus_req/busy fall immediately, no done. A start pulsed during REQ is ignored; a fresh start after reset completes normally.
